// File: rtl/emmc_cmd_serdes.sv
// ---------------------------------------------------------------------------
// emmc_cmd_serdes
//   CMD-line serializer/deserializer for a single eMMC device.
//   Sends a 40-bit command frame with CRC7 and end bit appended, optionally
//   captures a 48-bit (short) or 136-bit (long) response, checks its CRC7
//   and index, and reports the result with a one-cycle finish pulse.
//
// Ports
//   sd_clk      in   card clock, every register is rising-edge
//   rst         in   asynchronous active-high reset
//   start_i     in   launch pulse for cmd_i/setting_i
//   go_idle_i   in   abort the transaction in progress
//   setting_i   in   {long_response, expect_response}
//   cmd_i       in   {2'b01, index[5:0], argument[31:0]}
//   cmd_dat_i   in   CMD pin input (already synchronised)
//   cmd_out_o   out  CMD pin output value
//   cmd_oe_o    out  CMD pin output enable
//   response_o  out  response payload, left-aligned in 120 bits
//   crc_ok_o    out  response CRC7 and end bit good (valid with finish_o)
//   index_ok_o  out  response index matched (valid with finish_o)
//   finish_o    out  one-cycle pulse when a transaction completes
//   busy_o      out  high in every state except IDLE
//
// Handshake: start_i is a one-cycle request; it is taken only on a cycle in
// which busy_o is low and go_idle_i is low. Otherwise it is dropped, and the
// requester must wait for busy_o to fall before trying again.
// ---------------------------------------------------------------------------
module emmc_cmd_serdes #(
    parameter int INIT_DELAY = 80,
    parameter int NCR_MAX    = 64,
    parameter int NCR_MIN    = 2
) (
    input  logic         sd_clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         go_idle_i,
    input  logic [1:0]   setting_i,
    input  logic [39:0]  cmd_i,
    input  logic         cmd_dat_i,
    output logic         cmd_out_o,
    output logic         cmd_oe_o,
    output logic [119:0] response_o,
    output logic         crc_ok_o,
    output logic         index_ok_o,
    output logic         finish_o,
    output logic         busy_o
);

    localparam int IW = $clog2(INIT_DELAY + 1);
    localparam int NW = $clog2(NCR_MAX + 1);

    localparam logic [IW-1:0] INIT_LAST   = IW'(INIT_DELAY);
    localparam logic [NW-1:0] NCR_MIN_C   = NW'(NCR_MIN);
    localparam logic [NW-1:0] NCR_MAX_C   = NW'(NCR_MAX);
    localparam logic [NW-1:0] NCR_LAST    = NW'(NCR_MAX - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_WAIT_RSP,
        S_READ,
        S_FINISH
    } state_t;

    state_t         state;
    logic [IW-1:0]  init_cnt;
    logic [7:0]     bit_cnt;
    logic [NW-1:0]  ncr_cnt;
    logic [47:0]    tx_sr;
    logic [5:0]     cmd_idx;
    logic           long_rsp;
    logic           expect_rsp;
    logic [6:0]     crc;
    logic [6:0]     rx_crc;
    logic [5:0]     rx_idx;

    logic [47:0]    tx_frame;
    logic [7:0]     pos;
    logic [7:0]     pay_last;
    logic [7:0]     frame_last;
    logic [7:0]     crc_first;
    logic [6:0]     rsp_idx;
    logic [6:0]     crc_next;

    // One step of CRC7, generator x^7 + x^3 + 1, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            c = crc7_step(c, d[i]);
        end
        return c;
    endfunction

    // Response bit positions, counted with the start bit as position 0:
    //   short: 1 tx, 2..7 index, 8..39 payload, 40..46 CRC, 47 end
    //   long : 1 tx, 2..7 reserved, 8..127 payload, 128..134 CRC, 135 end
    // pos is the position of the bit being sampled on this edge.
    always_comb begin
        tx_frame   = {cmd_i, crc7_40(cmd_i), 1'b1};
        pos        = bit_cnt + 8'd1;
        pay_last   = long_rsp ? 8'd127 : 8'd39;
        frame_last = long_rsp ? 8'd135 : 8'd47;
        // Long responses protect only the payload; short ones also cover
        // tx and index bits (the leading zero start bit never changes CRC).
        crc_first  = long_rsp ? 8'd8 : 8'd1;
        rsp_idx    = 7'(8'd127 - pos);
        crc_next   = crc7_step(crc, cmd_dat_i);
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            bit_cnt    <= 8'd0;
            ncr_cnt    <= '0;
            tx_sr      <= 48'd0;
            cmd_idx    <= 6'd0;
            long_rsp   <= 1'b0;
            expect_rsp <= 1'b0;
            crc        <= 7'd0;
            rx_crc     <= 7'd0;
            rx_idx     <= 6'd0;
            cmd_out_o  <= 1'b1;
            cmd_oe_o   <= 1'b0;
            response_o <= 120'd0;
            crc_ok_o   <= 1'b0;
            index_ok_o <= 1'b0;
            finish_o   <= 1'b0;
            busy_o     <= 1'b1;
        end else begin
            finish_o <= 1'b0;
            case (state)
                // Drive CMD high for INIT_DELAY cycles of card power-up clocks.
                S_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state    <= S_IDLE;
                        cmd_oe_o <= 1'b0;
                        busy_o   <= 1'b0;
                    end else begin
                        init_cnt  <= init_cnt + IW'(1);
                        cmd_oe_o  <= 1'b1;
                        cmd_out_o <= 1'b1;
                    end
                end

                S_IDLE: begin
                    // go_idle_i takes priority: a coincident start is dropped.
                    if (start_i && !go_idle_i) begin
                        state      <= S_WRITE;
                        busy_o     <= 1'b1;
                        cmd_idx    <= cmd_i[37:32];
                        long_rsp   <= setting_i[1];
                        expect_rsp <= setting_i[0];
                        crc_ok_o   <= 1'b0;
                        index_ok_o <= 1'b0;
                        cmd_oe_o   <= 1'b1;
                        cmd_out_o  <= tx_frame[47];
                        tx_sr      <= {tx_frame[46:0], 1'b0};
                        bit_cnt    <= 8'd1;
                    end
                end

                // bit_cnt = number of frame bits already placed on the pin.
                S_WRITE: begin
                    if (go_idle_i) begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        cmd_oe_o  <= 1'b0;
                        cmd_out_o <= 1'b1;
                    end else if (bit_cnt == 8'd48) begin
                        cmd_oe_o  <= 1'b0;
                        cmd_out_o <= 1'b1;
                        if (expect_rsp) begin
                            state   <= S_WAIT_RSP;
                            ncr_cnt <= NW'(1);
                        end else begin
                            state    <= S_FINISH;
                            finish_o <= 1'b1;
                        end
                    end else begin
                        cmd_out_o <= tx_sr[47];
                        tx_sr     <= {tx_sr[46:0], 1'b0};
                        bit_cnt   <= bit_cnt + 8'd1;
                    end
                end

                // ncr_cnt = index of the released cycle being sampled
                // (1 = first cycle after the end bit).
                S_WAIT_RSP: begin
                    if (go_idle_i) begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        cmd_oe_o  <= 1'b0;
                        cmd_out_o <= 1'b1;
                    end else if (ncr_cnt > NCR_MIN_C && !cmd_dat_i) begin
                        state   <= S_READ;
                        bit_cnt <= 8'd0;
                        crc     <= 7'd0;
                        rx_crc  <= 7'd0;
                        rx_idx  <= 6'd0;
                        if (!long_rsp) begin
                            response_o[87:0] <= 88'd0;
                        end
                    end else if (ncr_cnt >= NCR_LAST) begin
                        // Timeout: flags stay cleared, response untouched.
                        state    <= S_FINISH;
                        finish_o <= 1'b1;
                    end else if (ncr_cnt != NCR_MAX_C) begin
                        ncr_cnt <= ncr_cnt + NW'(1);
                    end
                end

                S_READ: begin
                    if (go_idle_i) begin
                        state     <= S_IDLE;
                        busy_o    <= 1'b0;
                        cmd_oe_o  <= 1'b0;
                        cmd_out_o <= 1'b1;
                    end else begin
                        bit_cnt <= pos;
                        if (pos >= crc_first && pos <= pay_last) begin
                            crc <= crc_next;
                        end
                        if (pos >= 8'd2 && pos <= 8'd7) begin
                            rx_idx <= {rx_idx[4:0], cmd_dat_i};
                        end
                        if (pos >= 8'd8 && pos <= pay_last) begin
                            response_o[rsp_idx] <= cmd_dat_i;
                        end
                        if (pos > pay_last && pos < frame_last) begin
                            rx_crc <= {rx_crc[5:0], cmd_dat_i};
                        end
                        if (pos == frame_last) begin
                            crc_ok_o   <= (crc == rx_crc) && cmd_dat_i;
                            index_ok_o <= long_rsp ? 1'b1 : (rx_idx == cmd_idx);
                            finish_o   <= 1'b1;
                            state      <= S_FINISH;
                        end
                    end
                end

                S_FINISH: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end

                default: begin
                    state    <= S_INIT;
                    init_cnt <= '0;
                    busy_o   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_emmc_cmd_serdes.sv
// ---------------------------------------------------------------------------
// tb_emmc_cmd_serdes
//   Directed bench for emmc_cmd_serdes: reset/INIT, a table of no-response
//   commands with hand-computed CRC7 tails, short and long responses with
//   good/bad CRC, index and end bit, start-bit window edges, timeout, abort,
//   start/go_idle collision and asynchronous reset mid-command.
// ---------------------------------------------------------------------------
module tb_emmc_cmd_serdes;

    localparam int INIT_DELAY = 80;
    localparam int NCR_MAX    = 64;
    localparam int NCR_MIN    = 2;

    logic         sd_clk;
    logic         rst;
    logic         start_i;
    logic         go_idle_i;
    logic [1:0]   setting_i;
    logic [39:0]  cmd_i;
    logic         cmd_dat_i;
    logic         cmd_out_o;
    logic         cmd_oe_o;
    logic [119:0] response_o;
    logic         crc_ok_o;
    logic         index_ok_o;
    logic         finish_o;
    logic         busy_o;

    emmc_cmd_serdes #(
        .INIT_DELAY (INIT_DELAY),
        .NCR_MAX    (NCR_MAX),
        .NCR_MIN    (NCR_MIN)
    ) dut (
        .sd_clk     (sd_clk),
        .rst        (rst),
        .start_i    (start_i),
        .go_idle_i  (go_idle_i),
        .setting_i  (setting_i),
        .cmd_i      (cmd_i),
        .cmd_dat_i  (cmd_dat_i),
        .cmd_out_o  (cmd_out_o),
        .cmd_oe_o   (cmd_oe_o),
        .response_o (response_o),
        .crc_ok_o   (crc_ok_o),
        .index_ok_o (index_ok_o),
        .finish_o   (finish_o),
        .busy_o     (busy_o)
    );

    // ---------------- clock / reset ----------------
    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=no_end required=end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [39:0] cmd;
        logic [7:0]  tail;   // {CRC7, end bit}, hand-computed
    } cmd_vec_t;

    cmd_vec_t    vecs [4];
    logic [47:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    logic [119:0] exp_rsp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge sd_clk);
        #1;
    endtask

    // ---------------- reference CRC / frame builders ----------------
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic [6:0] r;
        r = {c[5:0], 1'b0};
        if (c[6] ^ b) r = r ^ 7'h09;
        return r;
    endfunction

    function automatic logic [6:0] crc7_bits(input logic [119:0] d, input int n);
        logic [6:0] c;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [47:0] cmd_frame(input logic [39:0] cmd);
        return {cmd, crc7_bits({80'd0, cmd}, 40), 1'b1};
    endfunction

    function automatic logic [135:0] r1_frame(input logic [5:0] idx, input logic [31:0] st,
                                              input logic [6:0] flip, input logic end_bit);
        logic [38:0] body;
        logic [6:0]  c;
        body = {1'b0, idx, st};
        c    = crc7_bits({81'd0, body}, 39);
        return {88'd0, 1'b0, body, c ^ flip, end_bit};
    endfunction

    function automatic logic [135:0] r2_frame(input logic [119:0] cid);
        return {1'b0, 1'b0, 6'h3F, cid, crc7_bits(cid, 120), 1'b1};
    endfunction

    // ---------------- drivers ----------------
    // Pulses start_i and captures the 48 pin bits; compares against exp_q.
    task automatic send_cmd(input logic [39:0] cmd, input logic [1:0] setting, input string tag);
        logic [47:0] pins;
        logic [47:0] exp;
        int          oe_low;
        start_i   = 1'b1;
        cmd_i     = cmd;
        setting_i = setting;
        tick;
        start_i = 1'b0;
        oe_low  = 0;
        for (int i = 0; i < 48; i++) begin
            pins[47-i] = cmd_out_o;
            if (cmd_oe_o !== 1'b1) oe_low++;
            tick;
        end
        exp = exp_q.pop_front();
        check($sformatf("%s pins", tag), 128'(pins), 128'(exp));
        check($sformatf("%s oe_low", tag), 128'(oe_low), 128'(0));
    endtask

    // pre_cycles released cycles at pre_val, then the frame MSB first.
    task automatic send_rsp(input logic [135:0] frame, input int len,
                            input int pre_cycles, input logic pre_val);
        for (int j = 0; j < pre_cycles; j++) begin
            cmd_dat_i = pre_val;
            tick;
        end
        for (int k = 0; k < len; k++) begin
            cmd_dat_i = frame[len-1-k];
            tick;
        end
        cmd_dat_i = 1'b1;
    endtask

    task automatic check_finish(input string tag, input int exp_wait, input logic exp_crc,
                                input logic exp_idx, input logic [119:0] exp_r);
        int n;
        n = 0;
        while (finish_o !== 1'b1 && n < 300) begin
            tick;
            n++;
        end
        check($sformatf("%s finish_wait", tag), 128'(n), 128'(exp_wait));
        check($sformatf("%s finish", tag), 128'(finish_o), 128'(1));
        check($sformatf("%s busy_at_finish", tag), 128'(busy_o), 128'(1));
        check($sformatf("%s oe_at_finish", tag), 128'(cmd_oe_o), 128'(0));
        check($sformatf("%s crc_ok", tag), 128'(crc_ok_o), 128'(exp_crc));
        check($sformatf("%s index_ok", tag), 128'(index_ok_o), 128'(exp_idx));
        check($sformatf("%s response", tag), 128'(response_o), 128'(exp_r));
        tick;
        check($sformatf("%s finish_drop", tag), 128'(finish_o), 128'(0));
        check($sformatf("%s busy_drop", tag), 128'(busy_o), 128'(0));
        check($sformatf("%s crc_hold", tag), 128'(crc_ok_o), 128'(exp_crc));
    endtask

    // ---------------- test ----------------
    initial begin
        int n_hi;
        int out_low;
        int fin_seen;
        logic [119:0] cid;

        rst       = 1'b1;
        start_i   = 1'b0;
        go_idle_i = 1'b0;
        setting_i = 2'b00;
        cmd_i     = 40'd0;
        cmd_dat_i = 1'b1;
        exp_rsp   = 120'd0;

        vecs[0] = '{cmd: 40'h40_0000_0000, tail: 8'h95};   // CMD0
        vecs[1] = '{cmd: 40'h48_0000_01AA, tail: 8'h87};   // CMD8
        vecs[2] = '{cmd: 40'h51_0000_0000, tail: 8'h55};   // CMD17
        vecs[3] = '{cmd: 40'h77_0000_0000, tail: 8'h65};   // CMD55

        // Reset values
        repeat (3) tick;
        check("rst oe", 128'(cmd_oe_o), 128'(0));
        check("rst out", 128'(cmd_out_o), 128'(1));
        check("rst response", 128'(response_o), 128'(0));
        check("rst crc_ok", 128'(crc_ok_o), 128'(0));
        check("rst index_ok", 128'(index_ok_o), 128'(0));
        check("rst finish", 128'(finish_o), 128'(0));
        check("rst busy", 128'(busy_o), 128'(1));

        // INIT: CMD driven high for INIT_DELAY cycles; a start in INIT is ignored
        rst     = 1'b0;
        n_hi    = 0;
        out_low = 0;
        for (int c = 0; c < 200; c++) begin
            tick;
            start_i = (c == 10);
            cmd_i   = 40'h40_0000_0000;
            if (cmd_oe_o !== 1'b1) break;
            if (cmd_out_o !== 1'b1) out_low++;
            n_hi++;
        end
        start_i = 1'b0;
        check("init oe_cycles", 128'(n_hi), 128'(INIT_DELAY));
        check("init out_low", 128'(out_low), 128'(0));
        check("init busy_fall", 128'(busy_o), 128'(0));
        tick;
        check("init start_ignored busy", 128'(busy_o), 128'(0));
        check("init start_ignored oe", 128'(cmd_oe_o), 128'(0));

        // No-response commands: pins vs hand-computed frames, finish 1 cycle after end bit
        for (int v = 0; v < 4; v++) begin
            exp_q.push_back({vecs[v].cmd, vecs[v].tail});
            send_cmd(vecs[v].cmd, 2'b00, $sformatf("vec%0d", v));
            check_finish($sformatf("vec%0d", v), 0, 1'b0, 1'b0, exp_rsp);
        end

        // CMD2 R2: long CID
        cid = {15{8'hA5}};
        exp_q.push_back(cmd_frame(40'h42_0000_0000));
        send_cmd(40'h42_0000_0000, 2'b11, "r2a");
        send_rsp(r2_frame(cid), 136, 4, 1'b1);
        exp_rsp = cid;
        check_finish("r2a", 0, 1'b1, 1'b1, exp_rsp);

        // CMD3 R1: status 0x500, start bit in the 5th released cycle
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "r1_good");
        send_rsp(r1_frame(6'd3, 32'h0000_0500, 7'h00, 1'b1), 48, 4, 1'b1);
        exp_rsp = {32'h0000_0500, 88'd0};
        check_finish("r1_good", 0, 1'b1, 1'b1, exp_rsp);

        // Same with one CRC bit flipped
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "r1_badcrc");
        send_rsp(r1_frame(6'd3, 32'h0000_0500, 7'h01, 1'b1), 48, 4, 1'b1);
        check_finish("r1_badcrc", 0, 1'b0, 1'b1, exp_rsp);

        // Wrong index, valid CRC
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "r1_badidx");
        send_rsp(r1_frame(6'd5, 32'h0000_0900, 7'h00, 1'b1), 48, 4, 1'b1);
        exp_rsp = {32'h0000_0900, 88'd0};
        check_finish("r1_badidx", 0, 1'b1, 1'b0, exp_rsp);

        // End bit 0 with valid CRC
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "r1_badend");
        send_rsp(r1_frame(6'd3, 32'hDEAD_BEEF, 7'h00, 1'b0), 48, 4, 1'b1);
        exp_rsp = {32'hDEAD_BEEF, 88'd0};
        check_finish("r1_badend", 0, 1'b0, 1'b1, exp_rsp);

        // Lows in the first NCR_MIN released cycles are ignored; start in cycle 3
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "r1_ncrmin");
        send_rsp(r1_frame(6'd3, 32'h1234_5678, 7'h00, 1'b1), 48, NCR_MIN, 1'b0);
        exp_rsp = {32'h1234_5678, 88'd0};
        check_finish("r1_ncrmin", 0, 1'b1, 1'b1, exp_rsp);

        // Latest accepted start bit: released cycle NCR_MAX-1
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "r1_late");
        send_rsp(r1_frame(6'd3, 32'h0BAD_F00D, 7'h00, 1'b1), 48, NCR_MAX - 2, 1'b1);
        exp_rsp = {32'h0BAD_F00D, 88'd0};
        check_finish("r1_late", 0, 1'b1, 1'b1, exp_rsp);

        // Timeout: finish rises NCR_MAX edges after the end bit appeared,
        // i.e. NCR_MAX-1 cycles after the first released cycle.
        exp_q.push_back(cmd_frame(40'h43_0000_0000));
        send_cmd(40'h43_0000_0000, 2'b01, "timeout");
        check_finish("timeout", NCR_MAX - 1, 1'b0, 1'b0, exp_rsp);

        // Second R2 so flags are set before the abort sequence
        cid = {15{8'h3C}};
        exp_q.push_back(cmd_frame(40'h42_0000_0000));
        send_cmd(40'h42_0000_0000, 2'b11, "r2b");
        send_rsp(r2_frame(cid), 136, 6, 1'b1);
        exp_rsp = cid;
        check_finish("r2b", 0, 1'b1, 1'b1, exp_rsp);

        // Abort at bit 20 of WRITE
        start_i   = 1'b1;
        cmd_i     = 40'h40_0000_0000;
        setting_i = 2'b01;
        tick;
        start_i = 1'b0;
        repeat (20) tick;
        go_idle_i = 1'b1;
        tick;
        go_idle_i = 1'b0;
        check("abort oe", 128'(cmd_oe_o), 128'(0));
        check("abort out", 128'(cmd_out_o), 128'(1));
        check("abort busy", 128'(busy_o), 128'(0));
        fin_seen = 0;
        for (int c = 0; c < 80; c++) begin
            if (finish_o === 1'b1) fin_seen++;
            tick;
        end
        check("abort no_finish", 128'(fin_seen), 128'(0));

        // start_i and go_idle_i together in IDLE: command dropped
        start_i   = 1'b1;
        go_idle_i = 1'b1;
        cmd_i     = 40'h40_0000_0000;
        setting_i = 2'b00;
        tick;
        start_i   = 1'b0;
        go_idle_i = 1'b0;
        check("collide busy", 128'(busy_o), 128'(0));
        check("collide oe", 128'(cmd_oe_o), 128'(0));

        // Next command after abort is accepted normally, flags cleared, response held
        exp_q.push_back(48'h40_0000_0000_95);
        send_cmd(40'h40_0000_0000, 2'b00, "post_abort");
        check_finish("post_abort", 0, 1'b0, 1'b0, exp_rsp);

        // Asynchronous reset in the middle of WRITE
        start_i = 1'b1;
        cmd_i   = 40'h51_0000_0000;
        tick;
        start_i = 1'b0;
        repeat (5) tick;
        #2;
        rst = 1'b1;
        #1;
        check("midrst oe", 128'(cmd_oe_o), 128'(0));
        check("midrst busy", 128'(busy_o), 128'(1));
        check("midrst response", 128'(response_o), 128'(0));
        tick;
        rst = 1'b0;
        tick;
        check("midrst init_oe", 128'(cmd_oe_o), 128'(1));
        check("midrst init_out", 128'(cmd_out_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
